ov5640_data_capture: RTL and testbench



---
 rtl/ov5640_pkg.sv | 23 ++
 rtl/ov5640_frame_gate.sv | 56 +++++
 rtl/ov5640_data_capture.sv | 64 ++++++
 tb/tb_ov5640_data_capture.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ov5640_pkg.sv
// Shared constants and pixel layout for the OV5640 DVP capture path.
// Holds the default frame-drop count, bus widths and the RGB565 field map.
package ov5640_pkg;

   localparam int unsigned OV5640_FRAME_DROP_DEF = 10;
   localparam int unsigned OV5640_PIX_W          = 16;
   localparam int unsigned OV5640_BYTE_W         = 8;

   // RGB565 field positions inside a 16-bit pixel
   localparam int unsigned RGB565_R_MSB = 15;
   localparam int unsigned RGB565_R_LSB = 11;
   localparam int unsigned RGB565_G_MSB = 10;
   localparam int unsigned RGB565_G_LSB = 5;
   localparam int unsigned RGB565_B_MSB = 4;
   localparam int unsigned RGB565_B_LSB = 0;

   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;

endpackage

// File: rtl/ov5640_frame_gate.sv
// Start-of-frame detection and start-up frame dropping.
// Ports:
//   clk, rst     - pixel clock, async active-high reset
//   vsync        - camera frame sync
//   sof_c        - combinational start-of-frame pulse (vsync rising edge)
//   frame_valid  - sticky flag, high once FRAME_DROP frames have passed
// Build option: OV5640_FRAME_DROP_EN enables the counter and flag; without
// it frame_valid is tied high and FRAME_DROP has no effect.
module ov5640_frame_gate
   import ov5640_pkg::*;
#(
   parameter int unsigned FRAME_DROP = OV5640_FRAME_DROP_DEF,
   parameter int unsigned CNT_W      = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic vsync,
   output logic sof_c,
   output logic frame_valid
);

   // Reject counter widths that cannot hold the drop count
   if (FRAME_DROP > 32'd15 || FRAME_DROP >= (32'd1 << CNT_W)) begin : g_param_check
      $error("ov5640_frame_gate: FRAME_DROP out of range for CNT_W");
   end

   logic vsync_d;

   // Previous vsync sample for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) vsync_d <= 1'b0;
      else     vsync_d <= vsync;
   end

   assign sof_c = vsync & ~vsync_d;

`ifdef OV5640_FRAME_DROP_EN
   localparam logic [CNT_W-1:0] DROP = CNT_W'(FRAME_DROP);

   logic [CNT_W-1:0] cnt;

   // Count frames up to DROP; the next frame start after that opens the gate
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         frame_valid <= 1'b0;
      end else if (sof_c) begin
         if (cnt < DROP)  cnt         <= cnt + CNT_W'(1);
         if (cnt == DROP) frame_valid <= 1'b1;
      end
   end
`else
   assign frame_valid = 1'b1;
`endif

endmodule

// File: rtl/ov5640_data_capture.sv
// OV5640 DVP capture front-end: pairs camera bytes into RGB565 pixels
// (first byte high) and suppresses output until start-up frames are dropped.
// Ports:
//   ov5640_pclk      - camera pixel clock (only clock)
//   sys_rst          - async active-high reset
//   ov5640_vsync     - frame sync
//   ov5640_href      - line valid
//   ov5640_data      - DVP byte bus
//   ov5640_wr_en     - one-cycle pixel write strobe
//   ov5640_data_out  - assembled pixel {first byte, second byte}
// Build option: OV5640_FRAME_DROP_EN enables start-up frame dropping.
module ov5640_data_capture
   import ov5640_pkg::*;
#(
   parameter int unsigned FRAME_DROP = OV5640_FRAME_DROP_DEF,
   parameter int unsigned CNT_W      = 4
) (
   input  logic                     ov5640_pclk,
   input  logic                     sys_rst,
   input  logic                     ov5640_vsync,
   input  logic                     ov5640_href,
   input  logic [OV5640_BYTE_W-1:0] ov5640_data,
   output logic                     ov5640_wr_en,
   output logic [OV5640_PIX_W-1:0]  ov5640_data_out
);

   logic                     sof_c;
   logic                     frame_valid;
   logic                     byte_sel;
   logic [OV5640_BYTE_W-1:0] hi_byte;
   logic                     pix_stb_c;

   ov5640_frame_gate #(
      .FRAME_DROP (FRAME_DROP),
      .CNT_W      (CNT_W)
   ) u_frame_gate (
      .clk         (ov5640_pclk),
      .rst         (sys_rst),
      .vsync       (ov5640_vsync),
      .sof_c       (sof_c),
      .frame_valid (frame_valid)
   );

   assign pix_stb_c = ov5640_href & byte_sel;

   // Byte pairing; byte_sel restarts at 0 whenever href drops, so an odd
   // trailing byte is simply never used
   always_ff @(posedge ov5640_pclk or posedge sys_rst) begin
      if (sys_rst) begin
         byte_sel        <= 1'b0;
         hi_byte         <= '0;
         ov5640_wr_en    <= 1'b0;
         ov5640_data_out <= '0;
      end else begin
         byte_sel <= ov5640_href ? ~byte_sel : 1'b0;
         // A stale high byte from an odd-length line is scrubbed at frame start
         if (ov5640_href && !byte_sel) hi_byte <= ov5640_data;
         else if (sof_c)               hi_byte <= '0;
         ov5640_wr_en <= pix_stb_c & frame_valid;
         if (pix_stb_c) ov5640_data_out <= {hi_byte, ov5640_data};
      end
   end

endmodule

// File: tb/tb_ov5640_data_capture.sv
// Scoreboard bench for ov5640_data_capture: two instances (FRAME_DROP=10 and
// FRAME_DROP=0) share one randomized DVP stream; expected pixels are derived
// per line from byte pairs and per frame from the frame count since reset.
module tb_ov5640_data_capture;

   typedef logic [7:0] byte_q_t[$];

   typedef struct {
      int          cyc;
      logic [15:0] data;
      bit          emit;
   } exp_t;

`ifdef OV5640_FRAME_DROP_EN
   localparam bit GATED = 1'b1;
`else
   localparam bit GATED = 1'b0;
`endif

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        vsync = 1'b0;
   logic        href  = 1'b0;
   logic [7:0]  data  = 8'h00;
   logic        wr_a, wr_b;
   logic [15:0] do_a, do_b;

   exp_t        qa[$];
   exp_t        qb[$];
   exp_t        ea, eb;
   int          cyc      = 0;
   int          vectors  = 0;
   int          errors   = 0;
   int          frames   = 0;
   logic [15:0] hold_a   = 16'h0;
   logic [15:0] hold_b   = 16'h0;

   byte_q_t line_a = '{8'hA0, 8'h50, 8'hA1, 8'h51, 8'hA2, 8'h52, 8'hA3, 8'h53};
   byte_q_t line_b = '{8'hB0, 8'h60, 8'hB1, 8'h61, 8'hB2, 8'h62, 8'hB3, 8'h63};
   byte_q_t line_s = '{8'h11, 8'h22};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ov5640_data_capture #(.FRAME_DROP(10), .CNT_W(4)) dut_a (
      .ov5640_pclk     (clk),
      .sys_rst         (rst),
      .ov5640_vsync    (vsync),
      .ov5640_href     (href),
      .ov5640_data     (data),
      .ov5640_wr_en    (wr_a),
      .ov5640_data_out (do_a)
   );

   ov5640_data_capture #(.FRAME_DROP(0), .CNT_W(4)) dut_b (
      .ov5640_pclk     (clk),
      .sys_rst         (rst),
      .ov5640_vsync    (vsync),
      .ov5640_href     (href),
      .ov5640_data     (data),
      .ov5640_wr_en    (wr_b),
      .ov5640_data_out (do_b)
   );

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endfunction

   // A frame is output once more than `drop` frame starts have been seen
   function automatic bit emit_ok(int drop);
      return GATED ? (frames > drop) : 1'b1;
   endfunction

   function automatic byte_q_t rand_line(int n);
      byte_q_t q;
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      return q;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_pair(logic [15:0] d);
      qa.push_back('{cyc: cyc + 1, data: d, emit: emit_ok(10)});
      qb.push_back('{cyc: cyc + 1, data: d, emit: emit_ok(0)});
   endtask

   task automatic send_vsync();
      vsync = 1'b1;
      frames++;
      tick();
      tick();
      vsync = 1'b0;
      repeat (3) tick();
   endtask

   task automatic send_line(input byte_q_t b, input int gap);
      for (int i = 0; i < b.size(); i++) begin
         href = 1'b1;
         data = b[i];
         if (i % 2 == 1) push_pair({b[i-1], b[i]});
         tick();
      end
      href = 1'b0;
      data = 8'($urandom);
      repeat (gap) tick();
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      href  = 1'b0;
      vsync = 1'b0;
      qa.delete();
      qb.delete();
      hold_a = 16'h0;
      hold_b = 16'h0;
      frames = 0;
      #1;
      chk("reset_now_a", 32'({wr_a, do_a}), 32'h0);
      chk("reset_now_b", 32'({wr_b, do_b}), 32'h0);
      repeat (3) tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic std_frame();
      send_vsync();
      send_line(line_a, 2);
      send_line(line_b, 3);
   endtask

   // Monitor: every cycle either the next scheduled pixel or an idle hold
   always @(negedge clk) begin
      if (rst) begin
         chk("reset_a", 32'({wr_a, do_a}), 32'h0);
         chk("reset_b", 32'({wr_b, do_b}), 32'h0);
      end else begin
         while (qa.size() > 0 && qa[0].cyc < cyc) begin
            ea = qa.pop_front();
            chk("missed_a", 32'({1'b0, 16'h0}), 32'({ea.emit, ea.data}));
         end
         if (qa.size() > 0 && qa[0].cyc == cyc) begin
            ea = qa.pop_front();
            chk("pix_a", 32'({wr_a, do_a}), 32'({ea.emit, ea.data}));
            hold_a = ea.data;
         end else begin
            chk("idle_a", 32'({wr_a, do_a}), 32'({1'b0, hold_a}));
         end

         while (qb.size() > 0 && qb[0].cyc < cyc) begin
            eb = qb.pop_front();
            chk("missed_b", 32'({1'b0, 16'h0}), 32'({eb.emit, eb.data}));
         end
         if (qb.size() > 0 && qb[0].cyc == cyc) begin
            eb = qb.pop_front();
            chk("pix_b", 32'({wr_b, do_b}), 32'({eb.emit, eb.data}));
            hold_b = eb.data;
         end else begin
            chk("idle_b", 32'({wr_b, do_b}), 32'({1'b0, hold_b}));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      repeat (4) tick();
      rst = 1'b0;
      tick();

      // Fixed-pattern frames across the drop boundary
      for (int f = 0; f < 15; f++) std_frame();

      // Steady 8-byte line, odd 7-byte line, then a 2-byte line
      send_vsync();
      send_line(line_a, 1);
      send_line(rand_line(7), 1);
      send_line(line_s, 2);

      // Reset mid-line during frame 12, then dropping restarts
      do_reset();
      for (int f = 0; f < 11; f++) std_frame();
      send_vsync();
      href = 1'b1;
      data = 8'hA0;
      tick();
      data = 8'h50;
      push_pair(16'hA050);
      tick();
      data = 8'hA1;
      tick();
      do_reset();

      // Randomized frames after the second reset
      for (int f = 0; f < 13; f++) begin
         send_vsync();
         for (int l = 0; l < int'($urandom_range(1, 3)); l++)
            send_line(rand_line(int'($urandom_range(1, 12))), int'($urandom_range(1, 5)));
      end

      repeat (6) tick();
      chk("drain_a", 32'(qa.size()), 32'h0);
      chk("drain_b", 32'(qb.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
